// File: rtl/nios_debug_ocimem_ctrl.sv
// rtl/nios_debug_ocimem_ctrl.sv - JTAG/CPU arbiter for the on-chip debug RAM
// Executes JTAG ocimem commands and CPU Avalon accesses, one at a time.
module nios_debug_ocimem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wr,
  output logic              ram_rd,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_JRD, S_JWR, S_CRD, S_CWR} state_t;
  typedef enum logic [1:0] {C_NONE, C_A, C_B, C_NA} cmd_t;

  localparam logic [1:0]        LAT = RAM_LAT[1:0];
  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_jptr;
  logic              r_pend_vld;
  cmd_t              r_pend_cmd;
  logic [33:0]       r_pend_jdo;
  logic              r_ack_pend;
  logic              r_cpu_done;
  logic [31:0]       r_mon_dreg;
  logic              r_ready;
  logic              r_err;
  logic [31:0]       r_avs_rdata;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [31:0]       r_ram_wdata;
  logic              r_ram_wr;
  logic              r_ram_rd;

  cmd_t              w_new_cmd;
  cmd_t              w_exec_cmd;
  logic [33:0]       w_exec_jdo;
  logic [ADDR_W-1:0] w_exec_addr;
  logic              w_exec_rd;
  logic              w_exec_clr;
  logic [31:0]       w_exec_data;
  logic              w_multi;
  logic              w_to_slot;
  logic              w_slot_free;
  logic              w_drop;
  logic              w_unused;

  assign w_unused = ^{jdo[37], jdo[2:0]};

  always_comb begin
    w_new_cmd = C_NONE;
    if (take_action_ocimem_a)         w_new_cmd = C_A;
    else if (take_action_ocimem_b)    w_new_cmd = C_B;
    else if (take_no_action_ocimem_a) w_new_cmd = C_NA;
  end

  assign w_multi = (take_action_ocimem_a & take_action_ocimem_b)
                 | (take_action_ocimem_a & take_no_action_ocimem_a)
                 | (take_action_ocimem_b & take_no_action_ocimem_a);

  // A queued command always runs before a fresh strobe; jdo is kept as bits [36:3].
  assign w_exec_cmd  = (r_state != S_IDLE) ? C_NONE : (r_pend_vld ? r_pend_cmd : w_new_cmd);
  assign w_exec_jdo  = r_pend_vld ? r_pend_jdo : jdo[36:3];
  assign w_exec_addr = w_exec_jdo[ADDR_W+13:14];
  assign w_exec_rd   = w_exec_jdo[32];
  assign w_exec_clr  = w_exec_jdo[33];
  assign w_exec_data = w_exec_jdo[31:0];

  assign w_to_slot   = (w_new_cmd != C_NONE) && ((r_state != S_IDLE) || r_pend_vld);
  assign w_slot_free = !r_pend_vld || (r_state == S_IDLE);
  assign w_drop      = w_to_slot && !w_slot_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_jptr      <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_cmd  <= C_NONE;
      r_pend_jdo  <= '0;
      r_ack_pend  <= 1'b0;
      r_cpu_done  <= 1'b0;
      r_mon_dreg  <= '0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_avs_rdata <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_wr    <= 1'b0;
      r_ram_rd    <= 1'b0;
    end else begin
      r_ram_rd   <= 1'b0;
      r_ram_wr   <= 1'b0;
      r_cpu_done <= 1'b0;
      r_ack_pend <= 1'b0;
      if (r_ack_pend) r_ready <= 1'b1;

      if ((r_state == S_IDLE) && r_pend_vld) r_pend_vld <= 1'b0;
      if (w_to_slot && w_slot_free) begin
        r_pend_vld <= 1'b1;
        r_pend_cmd <= w_new_cmd;
        r_pend_jdo <= jdo[36:3];
      end

      case (r_state)
        S_IDLE: begin
          if (w_exec_cmd != C_NONE) begin
            r_ready <= 1'b0;
            case (w_exec_cmd)
              C_A: begin
                r_jptr <= w_exec_addr;
                if (w_exec_clr) r_err <= 1'b0;
                if (w_exec_rd) begin
                  r_ram_rd   <= 1'b1;
                  r_ram_addr <= w_exec_addr;
                  r_cnt      <= '0;
                  r_state    <= S_JRD;
                end else begin
                  r_ack_pend <= 1'b1;
                end
              end
              C_NA: begin
                r_ram_rd   <= 1'b1;
                r_ram_addr <= r_jptr;
                r_cnt      <= '0;
                r_state    <= S_JRD;
              end
              C_B: begin
                r_ram_wr    <= 1'b1;
                r_ram_addr  <= r_jptr;
                r_ram_wdata <= w_exec_data;
                r_state     <= S_JWR;
              end
              default: ;
            endcase
          // cpu_done marks the cycle the CPU still holds its finished request.
          end else if ((avs_read || avs_write) && !r_cpu_done) begin
            r_ram_addr <= avs_address;
            if (avs_write) begin
              r_ram_wr    <= 1'b1;
              r_ram_wdata <= avs_writedata;
              r_state     <= S_CWR;
            end else begin
              r_ram_rd <= 1'b1;
              r_cnt    <= '0;
              r_state  <= S_CRD;
            end
          end
        end
        S_JRD: begin
          if (r_cnt == LAT) begin
            r_mon_dreg <= ram_rdata;
            r_ready    <= 1'b1;
            r_jptr     <= r_jptr + ONE;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_JWR: begin
          r_ready <= 1'b1;
          r_jptr  <= r_jptr + ONE;
          r_state <= S_IDLE;
        end
        S_CRD: begin
          if (r_cnt == LAT) begin
            r_avs_rdata <= ram_rdata;
            r_cpu_done  <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_CWR: begin
          r_cpu_done <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_multi || w_drop) r_err <= 1'b1;
    end
  end

  assign MonDReg         = r_mon_dreg;
  assign monitor_ready   = r_ready;
  assign monitor_error   = r_err;
  assign avs_readdata    = r_avs_rdata;
  assign avs_waitrequest = (avs_read | avs_write) & ~r_cpu_done;
  assign ram_addr        = r_ram_addr;
  assign ram_wdata       = r_ram_wdata;
  assign ram_wr          = r_ram_wr;
  assign ram_rd          = r_ram_rd;

endmodule
